// File: rtl/router_pkt_tx.sv
// Store-and-forward packet transmitter for a 3-port router: buffers a whole
// payload, then emits header, payload and parity under router back-pressure.
module router_pkt_tx #(
  parameter int MAX_LEN = 63
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_addr,
  input  logic [5:0] cmd_len,
  input  logic       cmd_bad_parity,
  output logic       cmd_err,
  input  logic [7:0] pay_data,
  input  logic       pay_valid,
  output logic       pay_ready,
  input  logic       busy,
  output logic [7:0] tx_data,
  output logic       tx_pkt_valid,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    HDR,
    PAY,
    PAR
  } state_t;

  localparam logic [5:0] MAX_LEN_W = 6'(MAX_LEN);

  state_t     state;
  state_t     next_state;

  logic [1:0] addr_q;
  logic [5:0] len_q;
  logic       bad_q;
  logic [5:0] wr_idx;
  logic [5:0] rd_idx;
  logic [7:0] par_q;
  logic [7:0] mem [0:MAX_LEN-1];

  logic       cmd_ok;
  logic       cmd_fire;
  logic       pay_fire;
  logic       consumed;
  logic       last_wr;
  logic       last_rd;
  logic [7:0] hdr_byte;

  assign cmd_ok   = (cmd_len != 6'd0) && (cmd_len <= MAX_LEN_W) && (cmd_addr != 2'd3);
  assign cmd_fire = cmd_valid && (state == IDLE);
  assign pay_fire = pay_valid && (state == LOAD);
  // The router takes the presented byte only on an edge where it is not stalled.
  assign consumed = !busy;
  assign last_wr  = (wr_idx == len_q - 6'd1);
  assign last_rd  = (rd_idx == len_q - 6'd1);
  assign hdr_byte = {len_q, addr_q};

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (cmd_fire && cmd_ok)        next_state = LOAD;
      LOAD: if (pay_fire && last_wr)       next_state = WAIT;
      WAIT: if (!busy)                     next_state = HDR;
      HDR:  if (consumed)                  next_state = PAY;
      PAY:  if (consumed && last_rd)       next_state = PAR;
      PAR:  if (consumed)                  next_state = IDLE;
      default:                             next_state = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready    = 1'b0;
    pay_ready    = 1'b0;
    tx_pkt_valid = 1'b0;
    tx_data      = 8'h00;
    case (state)
      IDLE: cmd_ready = 1'b1;
      LOAD: pay_ready = 1'b1;
      HDR: begin
        tx_pkt_valid = 1'b1;
        tx_data      = hdr_byte;
      end
      PAY: begin
        tx_pkt_valid = 1'b1;
        tx_data      = mem[rd_idx];
      end
      PAR: tx_data = par_q ^ {8{bad_q}};
      default: ;
    endcase
  end

  // Parity folds in bytes as they leave, so a byte held by busy counts once.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q  <= 2'd0;
      len_q   <= 6'd0;
      bad_q   <= 1'b0;
      wr_idx  <= 6'd0;
      rd_idx  <= 6'd0;
      par_q   <= 8'h00;
      cmd_err <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      cmd_err <= cmd_fire && !cmd_ok;
      tx_done <= (state == PAR) && consumed;

      if (cmd_fire && cmd_ok) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        bad_q  <= cmd_bad_parity;
        wr_idx <= 6'd0;
      end

      if (pay_fire) begin
        wr_idx <= wr_idx + 6'd1;
      end

      if ((state == HDR) && consumed) begin
        par_q  <= hdr_byte;
        rd_idx <= 6'd0;
      end

      if ((state == PAY) && consumed) begin
        par_q  <= par_q ^ mem[rd_idx];
        rd_idx <= rd_idx + 6'd1;
      end
    end
  end

  // NOTE: the payload buffer has no reset; every location read in PAY was
  // written in LOAD of the same packet, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (pay_fire) begin
      mem[wr_idx] <= pay_data;
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: normal packet, stalls, rejects, max length,
// parity error injection and reset in mid-packet.
module tb_router_pkt_tx;

  logic       clock;
  logic       resetn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_addr;
  logic [5:0] cmd_len;
  logic       cmd_bad_parity;
  logic       cmd_err;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       pay_ready;
  logic       busy;
  logic [7:0] tx_data;
  logic       tx_pkt_valid;
  logic       tx_done;

  int total = 0;
  int bad   = 0;

  logic [7:0] pay_q   [0:63];
  logic [7:0] exp_q   [0:65];
  int         stall_at[0:65];

  router_pkt_tx #(.MAX_LEN(63)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .cmd_bad_parity (cmd_bad_parity),
    .cmd_err        (cmd_err),
    .pay_data       (pay_data),
    .pay_valid      (pay_valid),
    .pay_ready      (pay_ready),
    .busy           (busy),
    .tx_data        (tx_data),
    .tx_pkt_valid   (tx_pkt_valid),
    .tx_done        (tx_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < 66; i++) stall_at[i] = 0;
  endtask

  // Expected router-side stream: header, payload bytes, then parity.
  task automatic build_exp(input logic [1:0] addr, input int len, input logic bad_par);
    logic [7:0] p;
    exp_q[0] = {6'(len), addr};
    p = exp_q[0];
    for (int i = 0; i < len; i++) begin
      exp_q[i+1] = pay_q[i];
      p = p ^ pay_q[i];
    end
    exp_q[len+1] = bad_par ? ~p : p;
  endtask

  task automatic issue_cmd(input logic [1:0] addr, input logic [5:0] len,
                           input logic bad_par, input logic want_err);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid      = 1'b1;
    cmd_addr       = addr;
    cmd_len        = len;
    cmd_bad_parity = bad_par;
    step();
    cmd_valid = 1'b0;
    check("cmd_err", cmd_err, want_err);
    check("pay_ready_after_cmd", pay_ready, !want_err);
    check("cmd_ready_after_cmd", cmd_ready, want_err);
    check("pv_after_cmd", tx_pkt_valid, 1'b0);
  endtask

  task automatic load_payload(input int len, input bit rand_valid, input bit poke_cmd);
    int i = 0;
    int guard = 0;
    while (i < len && guard < 2000) begin
      check("load_pay_ready", pay_ready, 1'b1);
      check("load_pv", tx_pkt_valid, 1'b0);
      check("load_cmd_err", cmd_err, 1'b0);
      pay_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      pay_data  = pay_q[i];
      if (poke_cmd) begin
        cmd_valid = 1'b1;
        cmd_addr  = 2'd3;
        cmd_len   = 6'd0;
      end
      step();
      guard++;
      if (pay_valid) i++;
    end
    pay_valid = 1'b0;
    cmd_valid = 1'b0;
    check("load_count", i, len);
    check("load_end_pay_ready", pay_ready, 1'b0);
    check("load_end_cmd_err", cmd_err, 1'b0);
  endtask

  // Follow the packet byte by byte; stall_at[k] cycles of busy hold byte k.
  task automatic collect(input int len);
    int k = 0;
    int hold = 0;
    int guard = 0;
    logic was_busy;
    check("wait_pv", tx_pkt_valid, 1'b0);
    check("wait_data", tx_data, 8'h00);
    busy = 1'b0;
    while (tx_pkt_valid !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    check("hdr_reached", tx_pkt_valid, 1'b1);
    guard = 0;
    while (k < len + 2 && guard < 500) begin
      check($sformatf("byte%0d", k), tx_data, exp_q[k]);
      check($sformatf("pv%0d", k), tx_pkt_valid, k <= len);
      check($sformatf("done_early%0d", k), tx_done, 1'b0);
      busy = (hold < stall_at[k]);
      was_busy = busy;
      if (was_busy) hold++;
      step();
      guard++;
      if (!was_busy) begin
        k++;
        hold = 0;
      end
    end
    busy = 1'b0;
    check("bytes_sent", k, len + 2);
    check("tx_done_pulse", tx_done, 1'b1);
    check("idle_after_pkt", cmd_ready, 1'b1);
    check("pv_after_pkt", tx_pkt_valid, 1'b0);
    check("data_after_pkt", tx_data, 8'h00);
    step();
    check("tx_done_single", tx_done, 1'b0);
  endtask

  initial begin
    int guard;
    resetn         = 1'b0;
    cmd_valid      = 1'b0;
    cmd_addr       = 2'd0;
    cmd_len        = 6'd0;
    cmd_bad_parity = 1'b0;
    pay_data       = 8'h00;
    pay_valid      = 1'b0;
    busy           = 1'b0;
    clear_stalls();

    repeat (2) @(posedge clock);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_pay_ready", pay_ready, 1'b0);
    check("rst_pv", tx_pkt_valid, 1'b0);
    check("rst_data", tx_data, 8'h00);
    check("rst_cmd_err", cmd_err, 1'b0);
    check("rst_done", tx_done, 1'b0);
    resetn = 1'b1;
    step();

    // Basic packet: header 0x0D, parity 0x0D^0x11^0x22^0x33.
    pay_q[0] = 8'h11; pay_q[1] = 8'h22; pay_q[2] = 8'h33;
    build_exp(2'd1, 3, 1'b0);
    check("hdr_const", exp_q[0], 8'h0D);
    issue_cmd(2'd1, 6'd3, 1'b0, 1'b0);
    load_payload(3, 1'b0, 1'b0);
    collect(3);

    // Same packet with router stalls on the header and mid-payload.
    clear_stalls();
    stall_at[0] = 2;
    stall_at[2] = 3;
    issue_cmd(2'd1, 6'd3, 1'b0, 1'b0);
    load_payload(3, 1'b0, 1'b0);
    collect(3);
    clear_stalls();

    // Rejected commands.
    issue_cmd(2'd3, 6'd5, 1'b0, 1'b1);
    step();
    check("err_single_a", cmd_err, 1'b0);
    check("rej_pay_ready_a", pay_ready, 1'b0);
    check("rej_pv_a", tx_pkt_valid, 1'b0);
    issue_cmd(2'd1, 6'd0, 1'b0, 1'b1);
    step();
    check("err_single_b", cmd_err, 1'b0);
    check("rej_pay_ready_b", pay_ready, 1'b0);
    check("rej_pv_b", tx_pkt_valid, 1'b0);

    // Maximum length with a bursty source and commands poked during LOAD.
    for (int i = 0; i < 63; i++) pay_q[i] = 8'(i * 37 + 5);
    build_exp(2'd0, 63, 1'b0);
    check("hdr_max", exp_q[0], 8'hFC);
    issue_cmd(2'd0, 6'd63, 1'b0, 1'b0);
    load_payload(63, 1'b1, 1'b1);
    collect(63);

    // Parity error injection.
    pay_q[0] = 8'hA5;
    build_exp(2'd2, 1, 1'b1);
    check("par_const", exp_q[2], 8'h5C);
    issue_cmd(2'd2, 6'd1, 1'b1, 1'b0);
    load_payload(1, 1'b0, 1'b0);
    collect(1);

    // Reset asserted while payload is being sent.
    pay_q[0] = 8'h01; pay_q[1] = 8'h02; pay_q[2] = 8'h04; pay_q[3] = 8'h08;
    issue_cmd(2'd1, 6'd4, 1'b0, 1'b0);
    load_payload(4, 1'b0, 1'b0);
    guard = 0;
    while (tx_pkt_valid !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    step();
    step();
    check("mid_pay_pv", tx_pkt_valid, 1'b1);
    check("mid_pay_data", tx_data, 8'h02);
    #2 resetn = 1'b0;
    #1;
    check("arst_cmd_ready", cmd_ready, 1'b1);
    check("arst_pay_ready", pay_ready, 1'b0);
    check("arst_pv", tx_pkt_valid, 1'b0);
    check("arst_data", tx_data, 8'h00);
    check("arst_cmd_err", cmd_err, 1'b0);
    check("arst_done", tx_done, 1'b0);
    step();
    resetn = 1'b1;
    step();
    check("post_rst_done", tx_done, 1'b0);

    pay_q[0] = 8'h5A; pay_q[1] = 8'hC3;
    build_exp(2'd2, 2, 1'b0);
    issue_cmd(2'd2, 6'd2, 1'b0, 1'b0);
    load_payload(2, 1'b0, 1'b0);
    collect(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
